unified_mem_arbiter: RTL and testbench

//  Shares one single-port synchronous SRAM between the pipeline's IF port (im_*) and MEM port (dm_*).

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/arb_rdata_hold.sv | 26 ++
 rtl/unified_mem_arbiter.sv | 97 +++++++++
 tb/tb_unified_mem_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter: grant/FSM tags and region select bits.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_IF    = 2'd1,
      S_DM_RD = 2'd2,
      S_DM_WR = 2'd3
   } arb_state_t;

   localparam logic REGION_IM = 1'b0;
   localparam logic REGION_DM = 1'b1;

endpackage

// File: rtl/arb_rdata_hold.sv
// Per-port read data capture; the previous-cycle grant tag selects which port latches mem_r_data.
module arb_rdata_hold
   import mem_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  arb_state_t            state,
   input  logic [DATA_WIDTH-1:0] mem_r_data,
   output logic [DATA_WIDTH-1:0] im_r_data,
   output logic [DATA_WIDTH-1:0] dm_r_data
);

   // Reset wins over capture so a read in flight at reset is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         im_r_data <= '0;
         dm_r_data <= '0;
      end else begin
         if (state == S_IF)    im_r_data <= mem_r_data;
         if (state == S_DM_RD) dm_r_data <= mem_r_data;
      end
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port SRAM arbiter between IF and MEM ports: DM priority with a bounded IF starvation window.
module unified_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int MAX_STARVE = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  im_rd,
   input  logic [ADDR_WIDTH-1:0] im_addr,
   output logic [DATA_WIDTH-1:0] im_r_data,
   output logic                  im_wait,
   input  logic                  dm_rd,
   input  logic                  dm_wr,
   input  logic [ADDR_WIDTH-1:0] dm_addr,
   input  logic [DATA_WIDTH-1:0] dm_w_data,
   output logic [DATA_WIDTH-1:0] dm_r_data,
   output logic                  dm_wait,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH:0]   mem_addr,
   output logic [DATA_WIDTH-1:0] mem_w_data,
   input  logic [DATA_WIDTH-1:0] mem_r_data
);

   localparam logic [3:0] STARVE_LIM = 4'(MAX_STARVE);

   arb_state_t state_q, state_d;
   logic [3:0] starve_cnt;
   logic       dm_req;
   logic       force_if;

   // state_d doubles as the current grant tag.
   always_comb begin
      state_d    = S_IDLE;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_w_data = '0;
      im_wait    = 1'b0;
      dm_wait    = 1'b0;
      dm_req     = dm_rd | dm_wr;
      force_if   = im_rd && (starve_cnt == STARVE_LIM);
      if (!rst) begin
         if (im_rd && (!dm_req || force_if)) state_d = S_IF;
         else if (dm_wr)                     state_d = S_DM_WR;
         else if (dm_rd)                     state_d = S_DM_RD;
         case (state_d)
            S_IF: begin
               mem_en   = 1'b1;
               mem_addr = {REGION_IM, im_addr};
            end
            S_DM_RD: begin
               mem_en   = 1'b1;
               mem_addr = {REGION_DM, dm_addr};
            end
            S_DM_WR: begin
               mem_en     = 1'b1;
               mem_we     = 1'b1;
               mem_addr   = {REGION_DM, dm_addr};
               mem_w_data = dm_w_data;
            end
            default: ;
         endcase
         im_wait = im_rd && (state_d != S_IF);
         dm_wait = dm_req && (state_d == S_IF);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst)
         starve_cnt <= '0;
      else if (!im_rd || state_d == S_IF)
         starve_cnt <= '0;
      else if (starve_cnt < STARVE_LIM)
         starve_cnt <= starve_cnt + 4'd1;
   end

   arb_rdata_hold #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rdata_hold (
      .clk        (clk),
      .rst        (rst),
      .state      (state_q),
      .mem_r_data (mem_r_data),
      .im_r_data  (im_r_data),
      .dm_r_data  (dm_r_data)
   );

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: behavioural SRAM plus a queue of expected port read data.
module tb_unified_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 8;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          im_rd, dm_rd, dm_wr;
   logic [AW-1:0] im_addr, dm_addr;
   logic [DW-1:0] dm_w_data, im_r_data, dm_r_data;
   logic          im_wait, dm_wait, mem_en, mem_we;
   logic [AW:0]   mem_addr;
   logic [DW-1:0] mem_w_data, mem_r_data;

   always #5 clk = ~clk;

   unified_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_STARVE(3)) dut (
      .clk(clk), .rst(rst),
      .im_rd(im_rd), .im_addr(im_addr), .im_r_data(im_r_data), .im_wait(im_wait),
      .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_w_data(dm_w_data),
      .dm_r_data(dm_r_data), .dm_wait(dm_wait),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
   );

   function automatic logic [DW-1:0] init_val(input int i);
      if (i == 5) return 16'hA5A5;
      return 16'(i * 16'h0137) ^ 16'h3C00;
   endfunction

   // Single-port synchronous SRAM; contents reload on reset.
   logic [DW-1:0] ram [0:511];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 512; i++) ram[i] <= init_val(i);
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_w_data;
         else        mem_r_data    <= ram[mem_addr];
      end
   end

   typedef struct {
      int            due;
      logic          is_dm;
      logic [DW-1:0] val;
   } pend_t;

   pend_t         pq[$];
   logic [DW-1:0] ref_mem [0:511];
   logic [DW-1:0] exp_im, exp_dm;
   int            total = 0;
   int            bad = 0;
   int            cyc = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic ref_reset();
      pq.delete();
      exp_im = '0;
      exp_dm = '0;
      for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
   endtask

   // g: expected grant this cycle, 0 none, 1 IF, 2 DM read, 3 DM write
   task automatic step(input logic r, input logic ir, input logic [AW-1:0] ia,
                       input logic dr, input logic dw, input logic [AW-1:0] da,
                       input logic [DW-1:0] wd, input int g);
      logic [AW:0] ea;
      pend_t       p;
      @(negedge clk);
      rst = r; im_rd = ir; im_addr = ia; dm_rd = dr; dm_wr = dw; dm_addr = da; dm_w_data = wd;
      #1;
      while (pq.size() > 0 && pq[0].due <= cyc) begin
         p = pq.pop_front();
         if (p.is_dm) exp_dm = p.val;
         else         exp_im = p.val;
      end
      ea = (g == 1) ? {1'b0, ia} : (g >= 2) ? {1'b1, da} : '0;
      chk("mem_en", 32'(mem_en), 32'(g != 0));
      chk("mem_we", 32'(mem_we), 32'(g == 3));
      chk("mem_addr", 32'(mem_addr), 32'(ea));
      chk("mem_w_data", 32'(mem_w_data), (g == 3) ? 32'(wd) : 32'd0);
      chk("im_wait", 32'(im_wait), 32'(!r && ir && g != 1));
      chk("dm_wait", 32'(dm_wait), 32'(!r && (dr || dw) && g == 1));
      chk("im_r_data", 32'(im_r_data), 32'(exp_im));
      chk("dm_r_data", 32'(dm_r_data), 32'(exp_dm));
      if (g == 1) pq.push_back('{cyc + 2, 1'b0, ref_mem[{1'b0, ia}]});
      if (g == 2) pq.push_back('{cyc + 2, 1'b1, ref_mem[{1'b1, da}]});
      if (g == 3) ref_mem[{1'b1, da}] = wd;
      @(posedge clk);
      cyc++;
      if (r) ref_reset();
   endtask

   task automatic idle(input int g_unused_n);
      for (int i = 0; i < g_unused_n; i++) step(0, 0, 8'h00, 0, 0, 8'h00, 16'h0, 0);
   endtask

   initial begin
      rst = 1'b1; im_rd = 0; im_addr = 0; dm_rd = 0; dm_wr = 0; dm_addr = 0; dm_w_data = 0;
      repeat (2) @(posedge clk);
      ref_reset();

      // reset state, requests ignored while rst is high
      step(1, 1, 8'h05, 1, 0, 8'h10, 16'h0, 0);

      // IF only, back-to-back grants
      step(0, 1, 8'h05, 0, 0, 8'h00, 16'h0, 1);
      step(0, 1, 8'h06, 0, 0, 8'h00, 16'h0, 1);
      idle(2);

      // contention: DM wins
      step(0, 1, 8'h05, 1, 0, 8'h10, 16'h0, 2);
      idle(2);

      // starvation: DM, DM, DM, forced IF, DM
      step(0, 1, 8'h07, 0, 1, 8'h20, 16'h0000, 3);
      step(0, 1, 8'h07, 0, 1, 8'h21, 16'h0001, 3);
      step(0, 1, 8'h07, 0, 1, 8'h22, 16'h0002, 3);
      step(0, 1, 8'h07, 0, 1, 8'h23, 16'h0003, 1);
      step(0, 1, 8'h07, 0, 1, 8'h24, 16'h0004, 3);
      idle(1);
      step(0, 0, 8'h00, 1, 0, 8'h22, 16'h0, 2);
      idle(2);

      // rd+wr together is a write; read it back
      step(0, 0, 8'h00, 1, 1, 8'hFF, 16'h1234, 3);
      step(0, 0, 8'h00, 1, 0, 8'hFF, 16'h0, 2);
      idle(2);

      // reset with an IF read in flight
      step(0, 1, 8'h09, 0, 0, 8'h00, 16'h0, 1);
      step(1, 1, 8'h09, 1, 0, 8'h10, 16'h0, 0);
      idle(3);

      // idle hold of nonzero port data
      step(0, 1, 8'h05, 0, 0, 8'h00, 16'h0, 1);
      step(0, 0, 8'h00, 1, 0, 8'h11, 16'h0, 2);
      idle(2);
      for (int i = 0; i < 3; i++) begin
         idle(1);
         #1 chk("state_idle", 32'(dut.state_q), 32'(S_IDLE));
      end
      chk("im_hold", 32'(im_r_data), 32'(16'hA5A5));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
